dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 2: data-memory access latency in cycles, legal range 1..15.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port i_ret_stbuf  input  1  store-buffer retire valid; fire-and-forget, never asserted while o_dmem_occupy=1.
REQ-005 Port i_ret_stbuf_addr  input  RV32_ADDR_WIDTH  retiring store address.
REQ-006 Port i_ret_stbuf_data  input  RV32_DATA_WIDTH  retiring store data.
REQ-007 Port o_dmem_occupy  output  1  port busy or claimed this cycle; store buffer shall not retire.
REQ-008 Port i_ld_req  input  1  load request valid, held until o_ld_ack.
REQ-009 Port i_ld_addr  input  RV32_ADDR_WIDTH  load address.
REQ-010 Port o_ld_ack  output  1  load accepted this cycle (combinational).
REQ-011 Port o_ld_done  output  1  one-cycle pulse, o_ld_data valid.
REQ-012 Port o_ld_data  output  RV32_DATA_WIDTH  load result, registered, held until next o_ld_done.
REQ-013 Ports o_mem_en, o_mem_we (output 1), o_mem_addr (output RV32_ADDR_WIDTH), o_mem_wdata (output RV32_DATA_WIDTH), i_mem_rdata (input RV32_DATA_WIDTH): single-port memory side.

Function
REQ-014 FSM states IDLE, LD, ST; a request is accepted only in IDLE.
REQ-015 Default arbitration: load wins; o_dmem_occupy = (state!=IDLE) | i_ld_req; o_ld_ack = (state==IDLE) & i_ld_req.
REQ-016 Store accepted when state==IDLE, i_ld_req=0, i_ret_stbuf=1.
REQ-017 Acceptance in cycle T latches address (and store data) into registers, loads latency counter with MEM_LAT-1, enters LD or ST at T+1.
REQ-018 During cycles T+1..T+MEM_LAT: o_mem_en=1, o_mem_we=1 only in ST, o_mem_addr/o_mem_wdata stable from latched registers.
REQ-019 Counter decrements each busy cycle; at count 0 in cycle T+MEM_LAT the FSM returns to IDLE for T+MEM_LAT+1.
REQ-020 LD: i_mem_rdata sampled at end of T+MEM_LAT into o_ld_data; o_ld_done=1 in T+MEM_LAT+1.
REQ-021 IDLE at T+MEM_LAT+1 accepts a new request that same cycle (back-to-back, no bubble beyond latency).
REQ-022 Outside busy cycles o_mem_en=0, o_mem_we=0; store completion produces no status output.
REQ-023 i_ret_stbuf asserted while o_dmem_occupy=1 is a protocol error; it is ignored.

Reset
REQ-024 rst_n low asynchronously forces IDLE, counter 0, o_mem_en=0, o_mem_we=0, o_ld_done=0, o_ld_data=0, latched address/data 0.
REQ-025 o_dmem_occupy=1 and o_ld_ack=0 while rst_n low.
REQ-026 Reset mid-access abandons the access; no o_ld_done for the in-flight load; first acceptance is possible in the first cycle after rst_n rises.

Configuration
REQ-027 Macro DMEM_CTRL_ST_PRIO_EN: undefined = load priority per REQ-015/016.
REQ-028 Defined: store wins; o_dmem_occupy = (state!=IDLE); o_ld_ack = (state==IDLE) & i_ld_req & ~i_ret_stbuf; no combinational path from i_ld_req to o_dmem_occupy.

Structure
REQ-029 RV32_ADDR_WIDTH, RV32_DATA_WIDTH, DMEM_LAT default and FSM state encodings live in constants.vh.
REQ-030 Single module, no sub-module; latency counter is 4 bits.

Verification (MEM_LAT=2 unless stated)
REQ-031 Idle load i_ld_addr=0x100, mem returns 0xDEADBEEF -> o_ld_ack at T, o_mem_en T+1..T+2, o_ld_done with 0xDEADBEEF at T+3.
REQ-032 Store 0x200/0x12345678 -> o_mem_we=1 T+1..T+2, o_dmem_occupy=1 T+1..T+2, 0 at T+3 with no request.
REQ-033 Same-cycle load 0x300 and store 0x400 -> default: load acked, store blocked until IDLE; with DMEM_CTRL_ST_PRIO_EN: store first, o_ld_ack at T+3.
REQ-034 Back-to-back loads at T and T+3 -> o_ld_done at T+3 and T+6, no extra idle cycle.
REQ-035 rst_n low at T+1 of a load -> o_mem_en=0 immediately, no o_ld_done, o_dmem_occupy=1 during reset.
REQ-036 MEM_LAT=1 and MEM_LAT=15 -> o_ld_done exactly at T+2 and T+16.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl shared constants and FSM state encoding.
// Included by every dmem_ctrl file through import dmem_ctrl_pkg::*.
package dmem_ctrl_pkg;

  localparam int RV32_ADDR_WIDTH = 32;
  localparam int RV32_DATA_WIDTH = 32;
  localparam int DMEM_LAT        = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LD   = 2'd1,
    ST   = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory port arbiter: load vs. store-buffer retire, fixed latency.
// Optional DMEM_CTRL_ST_PRIO_EN gives retiring stores priority over loads.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int MEM_LAT = DMEM_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_ret_stbuf,
  input  logic [RV32_ADDR_WIDTH-1:0] i_ret_stbuf_addr,
  input  logic [RV32_DATA_WIDTH-1:0] i_ret_stbuf_data,
  output logic                       o_dmem_occupy,
  input  logic                       i_ld_req,
  input  logic [RV32_ADDR_WIDTH-1:0] i_ld_addr,
  output logic                       o_ld_ack,
  output logic                       o_ld_done,
  output logic [RV32_DATA_WIDTH-1:0] o_ld_data,
  output logic                       o_mem_en,
  output logic                       o_mem_we,
  output logic [RV32_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [RV32_DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [RV32_DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  dmem_state_e                state;
  logic [CNT_W-1:0]           cnt;
  logic [RV32_ADDR_WIDTH-1:0] addr_q;
  logic [RV32_DATA_WIDTH-1:0] data_q;
  logic                       en_q;
  logic                       we_q;
  logic                       idle;
  logic                       ld_acc;
  logic                       st_acc;

  assign idle = (state == IDLE);

  // Occupy is forced high in reset so the store buffer never retires into it.
`ifdef DMEM_CTRL_ST_PRIO_EN
  assign st_acc        = idle & i_ret_stbuf;
  assign ld_acc        = idle & i_ld_req & ~i_ret_stbuf;
  assign o_dmem_occupy = ~rst_n | ~idle;
`else
  assign ld_acc        = idle & i_ld_req;
  assign st_acc        = idle & ~i_ld_req & i_ret_stbuf;
  assign o_dmem_occupy = ~rst_n | ~idle | i_ld_req;
`endif

  assign o_ld_ack    = rst_n & ld_acc;
  assign o_mem_en    = en_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      o_ld_done <= 1'b0;
      o_ld_data <= '0;
    end else begin
      o_ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_acc) begin
            state  <= LD;
            addr_q <= i_ld_addr;
            cnt    <= LAT_M1;
            en_q   <= 1'b1;
            we_q   <= 1'b0;
          end else if (st_acc) begin
            state  <= ST;
            addr_q <= i_ret_stbuf_addr;
            data_q <= i_ret_stbuf_data;
            cnt    <= LAT_M1;
            en_q   <= 1'b1;
            we_q   <= 1'b1;
          end
        end
        LD, ST: begin
          if (cnt == '0) begin
            state <= IDLE;
            en_q  <= 1'b0;
            we_q  <= 1'b0;
            if (state == LD) begin
              o_ld_data <= i_mem_rdata;
              o_ld_done <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// dmem_ctrl bench: directed scenarios plus random load/store traffic
// checked against a transaction-timing reference model.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ret_stbuf = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        occ;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_ack;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        x_req = 1'b0;
  logic [31:0] x_addr = '0;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = '0;
  logic        a_occ, a_ack, a_done, a_en, a_we;
  logic [31:0] a_data, a_addr, a_wdata, a_rdata;
  logic        b_occ, b_ack, b_done, b_en, b_we;
  logic [31:0] b_data, b_addr, b_wdata, b_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_ret_stbuf(ret_stbuf), .i_ret_stbuf_addr(st_addr),
    .i_ret_stbuf_data(st_data), .o_dmem_occupy(occ),
    .i_ld_req(ld_req), .i_ld_addr(ld_addr), .o_ld_ack(ld_ack),
    .o_ld_done(ld_done), .o_ld_data(ld_data),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  dmem_ctrl #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .i_ret_stbuf(zero1), .i_ret_stbuf_addr(zero32),
    .i_ret_stbuf_data(zero32), .o_dmem_occupy(a_occ),
    .i_ld_req(x_req), .i_ld_addr(x_addr), .o_ld_ack(a_ack),
    .o_ld_done(a_done), .o_ld_data(a_data),
    .o_mem_en(a_en), .o_mem_we(a_we), .o_mem_addr(a_addr),
    .o_mem_wdata(a_wdata), .i_mem_rdata(a_rdata)
  );

  dmem_ctrl #(.MEM_LAT(15)) u_lat15 (
    .clk(clk), .rst_n(rst_n),
    .i_ret_stbuf(zero1), .i_ret_stbuf_addr(zero32),
    .i_ret_stbuf_data(zero32), .o_dmem_occupy(b_occ),
    .i_ld_req(x_req), .i_ld_addr(x_addr), .o_ld_ack(b_ack),
    .o_ld_done(b_done), .o_ld_data(b_data),
    .o_mem_en(b_en), .o_mem_we(b_we), .o_mem_addr(b_addr),
    .o_mem_wdata(b_wdata), .i_mem_rdata(b_rdata)
  );

  assign a_rdata = a_en ? (32'hCAFE_0000 | a_addr) : 32'h0;
  assign b_rdata = b_en ? (32'hBEEF_0000 | b_addr) : 32'h0;

  logic [31:0] mem [0:1023];
  assign mem_rdata = mem_en ? mem[mem_addr[11:2]] : 32'h0;
  always @(posedge clk)
    if (mem_en && mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  // Reference model: one transaction at a time, LAT busy cycles each.
  logic [31:0] refmem [0:1023];
  logic [31:0] st_aq[$];
  logic [31:0] st_dq[$];
  int          done_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          busy_end = -1;
  int          done_cyc = -1;
  int          ack_seen = -1;
  logic        cur_st = 1'b0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_data = '0;
  logic [31:0] pend_data = '0;
  logic [31:0] exp_data = '0;
  logic        inj = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with ld_req/ld_addr already driven.
  task automatic cycle();
    logic idle, eocc, eack, est;
    idle = (cyc > busy_end);
`ifdef DMEM_CTRL_ST_PRIO_EN
    eocc = !idle;
`else
    eocc = !idle || ld_req;
`endif
    if (st_aq.size() > 0 && !eocc) begin
      ret_stbuf = 1'b1;
      st_addr   = st_aq[0];
      st_data   = st_dq[0];
    end else if (inj && eocc) begin
      ret_stbuf = 1'b1;
      st_addr   = 32'($urandom_range(0, 15)) << 2;
      st_data   = 32'hBAD0_0BAD;
    end else begin
      ret_stbuf = 1'b0;
    end
`ifdef DMEM_CTRL_ST_PRIO_EN
    eack = idle && ld_req && !ret_stbuf;
    est  = idle && ret_stbuf;
`else
    eack = idle && ld_req;
    est  = idle && !ld_req && ret_stbuf;
`endif
    #1;
    if (cyc == done_cyc) exp_data = pend_data;
    chk("occupy", 32'(occ), 32'(eocc));
    chk("ld_ack", 32'(ld_ack), 32'(eack));
    chk("mem_en", 32'(mem_en), 32'(!idle));
    chk("mem_we", 32'(mem_we), 32'(!idle && cur_st));
    chk("ld_done", 32'(ld_done), 32'(cyc == done_cyc));
    chk("ld_data", ld_data, exp_data);
    if (!idle) chk("mem_addr", mem_addr, cur_addr);
    if (!idle && cur_st) chk("mem_wdata", mem_wdata, cur_data);
    if (ld_ack) ack_seen = cyc;
    if (ld_done) done_q.push_back(cyc);
    if (eack) begin
      busy_end  = cyc + LAT;
      done_cyc  = cyc + LAT + 1;
      cur_st    = 1'b0;
      cur_addr  = ld_addr;
      pend_data = refmem[ld_addr[11:2]];
    end else if (est) begin
      busy_end  = cyc + LAT;
      cur_st    = 1'b1;
      cur_addr  = st_addr;
      cur_data  = st_data;
      refmem[st_addr[11:2]] = st_data;
      void'(st_aq.pop_front());
      void'(st_dq.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    ret_stbuf = 1'b0;
    if (eack) ld_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ld_req = 1'b1;
    #1;
    chk("rst_occupy", 32'(occ), 32'd1);
    chk("rst_ack", 32'(ld_ack), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_data", ld_data, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    ld_req   = 1'b0;
    busy_end = -1;
    done_cyc = -1;
    exp_data = '0;
    st_aq.delete();
    st_dq.delete();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  task automatic push_st(logic [31:0] a, logic [31:0] d);
    st_aq.push_back(a);
    st_dq.push_back(d);
  endtask

  initial begin
    int t0, k, d1, d15;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 32'(i) * 32'h0101_0101;
      refmem[i] = 32'(i) * 32'h0101_0101;
    end
    mem[32'h100 >> 2]    = 32'hDEAD_BEEF;
    refmem[32'h100 >> 2] = 32'hDEAD_BEEF;
    #1;
    do_reset();

    // single load
    ld_req = 1'b1; ld_addr = 32'h100;
    for (int i = 0; i < 4; i++) cycle();
    chk("ld_deadbeef", ld_data, 32'hDEAD_BEEF);

    // single store, then port free again
    push_st(32'h200, 32'h1234_5678);
    for (int i = 0; i < 4; i++) cycle();
    chk("st_written", mem[32'h200 >> 2], 32'h1234_5678);

    // same-cycle load and store
    push_st(32'h400, 32'hA5A5_5A5A);
    ld_req = 1'b1; ld_addr = 32'h300;
    t0 = cyc; ack_seen = -1;
    for (int i = 0; i < 8; i++) cycle();
`ifdef DMEM_CTRL_ST_PRIO_EN
    chk("race_ack_cyc", 32'(ack_seen - t0), 32'd3);
`else
    chk("race_ack_cyc", 32'(ack_seen - t0), 32'd0);
`endif
    chk("race_st_written", mem[32'h400 >> 2], 32'hA5A5_5A5A);

    // back-to-back loads
    done_q.delete();
    t0 = cyc;
    ld_req = 1'b1; ld_addr = 32'h200;
    for (int i = 0; i < 3; i++) cycle();
    ld_req = 1'b1; ld_addr = 32'h100;
    for (int i = 0; i < 4; i++) cycle();
    chk("b2b_count", 32'(done_q.size()), 32'd2);
    if (done_q.size() >= 2) begin
      chk("b2b_first", 32'(done_q[0] - t0), 32'd3);
      chk("b2b_second", 32'(done_q[1] - t0), 32'd6);
    end
    chk("b2b_data", ld_data, 32'hDEAD_BEEF);

    // reset in the first busy cycle of a load
    ld_req = 1'b1; ld_addr = 32'h300;
    cycle();
    done_q.delete();
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    chk("rst_no_done", 32'(done_q.size()), 32'd0);

    // latency extremes
    x_req = 1'b1; x_addr = 32'h40;
    #1;
    chk("lat1_ack", 32'(a_ack), 32'd1);
    chk("lat15_ack", 32'(b_ack), 32'd1);
    @(posedge clk);
    #1;
    cyc++;
    x_req = 1'b0;
    k = 1; d1 = -1; d15 = -1;
    while (k <= 40 && (d1 < 0 || d15 < 0)) begin
      if (a_done && d1 < 0) d1 = k;
      if (b_done && d15 < 0) d15 = k;
      @(posedge clk);
      #1;
      cyc++;
      k++;
    end
    chk("lat1_done_cyc", 32'(d1), 32'd2);
    chk("lat15_done_cyc", 32'(d15), 32'd16);
    chk("lat1_data", a_data, 32'hCAFE_0040);
    chk("lat15_data", b_data, 32'hBEEF_0040);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      if (!ld_req && $urandom_range(0, 7) == 0) begin
        ld_req  = 1'b1;
        ld_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if ($urandom_range(0, 7) == 0)
        push_st(32'($urandom_range(0, 15)) << 2, $urandom);
      inj = ($urandom_range(0, 9) == 0);
      cycle();
      inj = 1'b0;
    end
    k = 0;
    while (k < 300 && (st_aq.size() > 0 || ld_req || cyc <= busy_end + 1)) begin
      cycle();
      k++;
    end
    chk("drain_bound", 32'(k < 300), 32'd1);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mem_%0d", i), mem[i], refmem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
